// File: rtl/pulse_stretcher_pkg.sv
// Shared types for the pulse stretcher: the phase state encoding.
package pulse_stretcher_pkg;

  // Waveform phase: waiting, driving the level high, or holding the low gap.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } ps_state_e;

endpackage : pulse_stretcher_pkg

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle request pulses into fixed-length high
// levels separated by a mandatory low gap. Requests arriving mid-waveform are
// queued in a saturating counter; a request that finds the queue full is
// dropped and recorded in a sticky overflow flag.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int HIGH_CYCLES = 4,
  parameter  int LOW_CYCLES  = 2,
  parameter  int PEND_DEPTH  = 3,
  localparam int PEND_W      = $clog2(PEND_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pulse_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  // The phase counter must hold the longer of the two phases; keep at least
  // one bit so the single-cycle configuration still has a legal vector.
  localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_DEPTH);

  ps_state_e         state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [PEND_W-1:0] pending_r, pending_nxt;
  logic              level_r;
  logic              overflow_r;

  logic              req;
  logic              start;
  logic              inc;
  logic              dec;
  logic              drop;

  // Next-state and phase-counter logic; a new waveform starts from IDLE or
  // straight out of the last gap cycle when a request is waiting.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    req       = pulse_i || (pending_r != '0);
    start     = 1'b0;
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          start     = 1'b1;
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end
      end
      HIGH: begin
        if (cnt_r == HIGH_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_r == LOW_LAST) begin
          cnt_nxt = '0;
          if (req) begin
            start     = 1'b1;
            state_nxt = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Queue bookkeeping: each started waveform consumes one request, each
  // accepted pulse adds one; a pulse that can start immediately nets to zero.
  always_comb begin
    dec         = start;
    inc         = pulse_i && ((pending_r < PEND_FULL) || dec);
    drop        = pulse_i && (pending_r == PEND_FULL) && !dec;
    pending_nxt = pending_r + PEND_W'(inc) - PEND_W'(dec);
  end

  // State, counter, queue, output level and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      pending_r  <= '0;
      level_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      pending_r <= pending_nxt;
      level_r   <= (state_nxt == HIGH);
      if (drop) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign level_o    = level_r;
  assign busy_o     = (state_r != IDLE);
  assign pending_o  = pending_r;
  assign overflow_o = overflow_r;

endmodule : pulse_stretcher

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a default-parameter instance covers the
// single, held, overflow, last-gap and reset scenarios; a HIGH=1/LOW=1
// instance covers the minimum-length waveform. Edge n is the n-th rising edge
// after the pulse is first driven; outputs are sampled 1 ns after each edge.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       pulse_min;

  logic       level, busy, overflow;
  logic [1:0] pending;
  logic       level_m, busy_m, overflow_m;
  logic [1:0] pending_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES(4),
    .LOW_CYCLES (2),
    .PEND_DEPTH (3)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .pulse_i   (pulse),
    .level_o   (level),
    .busy_o    (busy),
    .pending_o (pending),
    .overflow_o(overflow)
  );

  pulse_stretcher #(
    .HIGH_CYCLES(1),
    .LOW_CYCLES (1),
    .PEND_DEPTH (3)
  ) dut_min (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .pulse_i   (pulse_min),
    .level_o   (level_m),
    .busy_o    (busy_m),
    .pending_o (pending_m),
    .overflow_o(overflow_m)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges and release it away from any edge; return
  // 1 ns after the following edge, ready to drive edge-0 stimulus.
  task automatic do_reset();
    pulse     = 1'b0;
    pulse_min = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    pulse     = 1'b0;
    pulse_min = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if ({level, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: got %b want 00000", {level, busy, pending, overflow});
    end
    checks++;
    if ({level_m, busy_m, pending_m, overflow_m} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async_min: got %b want 00000", {level_m, busy_m, pending_m, overflow_m});
    end
    tick();
    checks++;
    if ({level, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got %b want 00000", {level, busy, pending, overflow});
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic exp_l, exp_b;
    do_reset();
    pulse = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_l = (n >= 1 && n <= 4);
      exp_b = (n >= 1 && n <= 6);
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL single_level edge %0d: got %b want %b", n, level, exp_l);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL single_busy edge %0d: got %b want %b", n, busy, exp_b);
      end
      checks++;
      if (pending !== 2'd0) begin
        errors++;
        $display("FAIL single_pending edge %0d: got %0d want 0", n, pending);
      end
      if (n == 1) pulse = 1'b0;
    end
  endtask

  task automatic test_held();
    logic       exp_l, exp_b;
    logic [1:0] exp_p;
    do_reset();
    pulse = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_l = (n >= 1 && n <= 4) || (n >= 7 && n <= 10) || (n >= 13 && n <= 16);
      exp_b = (n <= 18);
      exp_p = (n <= 1) ? 2'd0 : (n == 2) ? 2'd1 : (n <= 6) ? 2'd2 : (n <= 12) ? 2'd1 : 2'd0;
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL held_level edge %0d: got %b want %b", n, level, exp_l);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL held_busy edge %0d: got %b want %b", n, busy, exp_b);
      end
      checks++;
      if (pending !== exp_p) begin
        errors++;
        $display("FAIL held_pending edge %0d: got %0d want %0d", n, pending, exp_p);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL held_overflow edge %0d: got %b want 0", n, overflow);
      end
      if (n == 3) pulse = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic       exp_l, exp_b, exp_o, prev;
    logic [1:0] exp_p;
    int         rises;
    do_reset();
    rises = 0;
    prev  = 1'b0;
    pulse = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      tick();
      exp_l = (n >= 1 && n <= 4) || (n >= 7 && n <= 10) ||
              (n >= 13 && n <= 16) || (n >= 19 && n <= 22);
      exp_b = (n <= 24);
      exp_o = (n >= 5);
      exp_p = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : (n == 3) ? 2'd2 : (n <= 6) ? 2'd3 :
              (n <= 12) ? 2'd2 : (n <= 18) ? 2'd1 : 2'd0;
      if (level && !prev) rises++;
      prev = level;
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL ovf_level edge %0d: got %b want %b", n, level, exp_l);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL ovf_busy edge %0d: got %b want %b", n, busy, exp_b);
      end
      checks++;
      if (pending !== exp_p) begin
        errors++;
        $display("FAIL ovf_pending edge %0d: got %0d want %0d", n, pending, exp_p);
      end
      checks++;
      if (overflow !== exp_o) begin
        errors++;
        $display("FAIL ovf_flag edge %0d: got %b want %b", n, overflow, exp_o);
      end
      if (n == 6) pulse = 1'b0;
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL ovf_waveforms: got %0d want 4", rises);
    end
  endtask

  // Pulse in the last gap cycle restarts at once; a pulse in the first gap
  // cycle of the next waveform is queued for one gap cycle instead.
  task automatic test_last_gap();
    logic       exp_l, exp_b;
    logic [1:0] exp_p;
    do_reset();
    pulse = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_l = (n >= 1 && n <= 4) || (n >= 7 && n <= 10) || (n >= 13 && n <= 16);
      exp_b = (n <= 18);
      exp_p = (n == 12) ? 2'd1 : 2'd0;
      checks++;
      if (level !== exp_l) begin
        errors++;
        $display("FAIL gap_level edge %0d: got %b want %b", n, level, exp_l);
      end
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL gap_busy edge %0d: got %b want %b", n, busy, exp_b);
      end
      checks++;
      if (pending !== exp_p) begin
        errors++;
        $display("FAIL gap_pending edge %0d: got %0d want %0d", n, pending, exp_p);
      end
      pulse = (n == 6) || (n == 11);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
    end
    pulse = 1'b0;
    checks++;
    if ({level, pending} !== 3'b110) begin
      errors++;
      $display("FAIL mid_setup: got level=%b pending=%0d want level=1 pending=2", level, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({level, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async: got %b want 00000", {level, busy, pending, overflow});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      checks++;
      if ({level, busy, pending} !== 4'b0) begin
        errors++;
        $display("FAIL mid_after edge %0d: got %b want 0000", n, {level, busy, pending});
      end
    end
  endtask

  task automatic test_min();
    logic       exp_l, exp_o;
    logic [1:0] exp_p;
    do_reset();
    pulse_min = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_l = (n % 2 == 1);
      exp_o = (n >= 8);
      exp_p = (n == 1) ? 2'd0 : (n <= 3) ? 2'd1 : (n <= 5) ? 2'd2 : 2'd3;
      checks++;
      if (level_m !== exp_l) begin
        errors++;
        $display("FAIL min_level edge %0d: got %b want %b", n, level_m, exp_l);
      end
      checks++;
      if (pending_m !== exp_p) begin
        errors++;
        $display("FAIL min_pending edge %0d: got %0d want %0d", n, pending_m, exp_p);
      end
      checks++;
      if (overflow_m !== exp_o) begin
        errors++;
        $display("FAIL min_overflow edge %0d: got %b want %b", n, overflow_m, exp_o);
      end
    end
    pulse_min = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_last_gap();
    test_reset_mid();
    test_min();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_stretcher

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses into clean, button-like level waveforms: each accepted request produces `level_o` high for a fixed number of cycles, followed by a mandatory low gap. Requests that arrive while a waveform is in progress are queued in a saturating counter. Queue overflow is flagged with a sticky error bit. The block sits downstream of the button pulse generator, turning event pulses back into human- or peripheral-visible levels such as LED blinks or emulated button presses for loopback testing.

## Interface
Parameters:
- `HIGH_CYCLES`, default 4: cycles `level_o` stays high per request; must be ≥ 1.
- `LOW_CYCLES`, default 2: minimum low gap after each high phase; must be ≥ 1.
- `PEND_DEPTH`, default 3: maximum number of queued requests; must be ≥ 1.
- `PEND_W`, derived as `$clog2(PEND_DEPTH+1)`: width of the pending count.

Ports:
- `clk_i`, in, 1: the single clock; all logic is rising-edge.
- `rst_n_i`, in, 1: reset, asynchronous and active-low.
- `pulse_i`, in, 1: request input; every cycle it is sampled high counts as one request.
- `level_o`, out, 1: stretched output level, driven directly from a register.
- `busy_o`, out, 1: high when the state is not IDLE.
- `pending_o`, out, PEND_W: number of queued requests not yet started.
- `overflow_o`, out, 1: sticky; set when a request is dropped, cleared only by reset.

## Operation
- The state machine has three states: IDLE, HIGH and GAP. A phase counter `cnt_r` (width `$clog2(max(HIGH_CYCLES, LOW_CYCLES))`) runs alongside it.
- `start` is asserted in either of these cases:
  - state is IDLE and (`pulse_i` or `pending_r != 0`);
  - state is GAP, `cnt_r == LOW_CYCLES-1`, and (`pulse_i` or `pending_r != 0`).
- State transitions:
  - On `start`: go to HIGH with `cnt_r = 0`.
  - In HIGH: increment `cnt_r`. At `cnt_r == HIGH_CYCLES-1`, go to GAP with `cnt_r = 0`.
  - In GAP: increment `cnt_r`. At `cnt_r == LOW_CYCLES-1`, go to HIGH if `start`, otherwise go to IDLE.
  - Unreachable encodings return to IDLE.
- Queue arithmetic:
  - `dec = start`.
  - `inc = pulse_i && (pending_r < PEND_DEPTH || dec)`.
  - `pending_r <= pending_r + inc - dec`.
  - A simultaneous increment and decrement leaves the count unchanged. The count never wraps and never exceeds `PEND_DEPTH`.
  - A pulse that arrives in IDLE with an empty queue is consumed immediately; `pending_o` stays 0.
- Overflow: when `pulse_i && pending_r == PEND_DEPTH && !dec`, the request is dropped and `overflow_r <= 1`.
- Output registers:
  - `level_o` is registered with `level_o <= (next_state == HIGH)`.
  - `busy_o` is combinational from `state_r`.

## Timing
- Reset values: state IDLE, `cnt_r` 0, `level_o` 0, `busy_o` 0, `pending_o` 0, `overflow_o` 0. Asserting reset mid-operation clears everything immediately, asynchronously, and discards all queued requests.
- Latency: `pulse_i` sampled at edge k in IDLE puts `level_o` high from edge k+1 through edge k+HIGH_CYCLES inclusive. It is then low for LOW_CYCLES cycles.
- Back-to-back requests have a period of exactly HIGH_CYCLES+LOW_CYCLES, with no IDLE cycle between waveforms.
- A pulse in any GAP cycle other than the last is queued. A pulse in the last GAP cycle starts the next high phase with no queuing delay.
- `pending_o` and `overflow_o` update one edge after the sampling edge.

## Structure
- A shared package `pulse_stretcher_pkg` holds the state enum typedef `ps_state_e` (IDLE, HIGH, GAP; 2-bit encoding).
- The block is a single module with no sub-module. Queue, counter and state machine are all small enough to stay inline.

## Test plan
Scenarios 1–5 use the default parameters (HIGH_CYCLES=4, LOW_CYCLES=2, PEND_DEPTH=3).

1. **Single pulse.** Drive `pulse_i` high for 1 cycle at edge 0.
   - `level_o` is high for edges 1–4 and low for edges 5–6.
   - `busy_o` is high for edges 1–6 and low at edge 7.
   - `pending_o` stays 0.
2. **Held pulse.** Hold `pulse_i` high for 3 cycles.
   - Three 4-high/2-low waveforms are produced back to back.
   - `pending_o` reads 1, then 2, then drains to 0.
   - `overflow_o` stays 0.
3. **Overflow.** Drive 6 consecutive pulses from IDLE.
   - `pending_o` saturates at 3.
   - `overflow_o` rises at edge 5 and stays high.
   - Exactly 4 waveforms are produced.
4. **Last-gap pulse.** Pulse on the final GAP cycle of a waveform.
   - `level_o` goes high at the very next edge, with no IDLE cycle in between.
5. **Reset mid-operation.** Assert `rst_n_i` low during HIGH with `pending_o` = 2.
   - `level_o`, `busy_o` and `pending_o` go to 0 immediately.
   - No further waveforms appear after reset is released.
6. **Minimum parameters.** Set HIGH_CYCLES=1, LOW_CYCLES=1 and drive continuous pulses.
   - `level_o` alternates 1,0,1,0…
   - `overflow_o` eventually sets.
